// File: rtl/timer_pkg.sv
// Shared types and constants for the memory-mapped countdown timer.
// TIMER_AUTORELOAD_EN (see timer_dev) enables the auto-reload MODE field.
package timer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_CNT  = 2'd2,
    ST_INT  = 2'd3
  } state_t;

  localparam logic [1:0] OFF_CTRL   = 2'd0;
  localparam logic [1:0] OFF_PRESET = 2'd1;
  localparam logic [1:0] OFF_COUNT  = 2'd2;

  localparam int unsigned CTRL_EN_BIT   = 0;
  localparam int unsigned CTRL_MODE_LSB = 1;
  localparam int unsigned CTRL_MODE_MSB = 2;
  localparam int unsigned CTRL_IM_BIT   = 3;
  localparam int unsigned CTRL_W        = 4;
  localparam int unsigned BUS_W         = 32;

  localparam logic [1:0] MODE_ONESHOT = 2'd0;
  localparam logic [1:0] MODE_RELOAD  = 2'd1;

  // Field order matches the CTRL bit positions above (im is bit 3, en is bit 0).
  typedef struct packed {
    logic       im;
    logic [1:0] mode;
    logic       en;
  } ctrl_t;

  function automatic logic [BUS_W-1:0] ctrl_word(input ctrl_t c);
    return {(BUS_W - CTRL_W)'(0), c};
  endfunction

endpackage

// File: rtl/timer_dev_if.sv
// CPU bridge port of the timer: word offset, write strobe, write and read data.
interface timer_dev_if;
  logic [1:0]  addr;
  logic        we;
  logic [31:0] wdata;
  logic [31:0] rdata;

  modport master (output addr, output we, output wdata, input rdata);
  modport slave  (input addr, input we, input wdata, output rdata);
endinterface

// File: rtl/timer_fsm.sv
// Countdown sequencer: state register, COUNT and the sticky one-shot pending flag.
module timer_fsm
  import timer_pkg::*;
#(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic [CNT_W-1:0] preset,
  input  logic             reg_write,
  output logic [CNT_W-1:0] count,
  output logic             in_int,
  output logic             pending,
  output logic             en_clr_c
);

  state_t           state, state_nxt;
  logic [CNT_W-1:0] count_nxt;
  logic             pending_nxt;
  logic             auto_reload;

  // Encodings 2 and 3 fall back to one-shot.
  assign auto_reload = (mode == MODE_RELOAD);
  assign in_int      = (state == ST_INT);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= ST_IDLE;
      count   <= '0;
      pending <= 1'b0;
    end else begin
      state   <= state_nxt;
      count   <= count_nxt;
      pending <= pending_nxt;
    end
  end

  // Pending is raised on entry to INT so a one-shot irq appears together with INT.
  always_comb begin
    state_nxt   = state;
    count_nxt   = count;
    pending_nxt = pending;
    en_clr_c    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (en) state_nxt = ST_LOAD;
      end
      ST_LOAD: begin
        count_nxt = preset;
        state_nxt = ST_CNT;
      end
      ST_CNT: begin
        if (!en) begin
          state_nxt = ST_IDLE;
        end else if (count == '0) begin
          state_nxt = ST_INT;
          if (!auto_reload) pending_nxt = 1'b1;
        end else begin
          count_nxt = count - CNT_W'(1);
        end
      end
      ST_INT: begin
        if (auto_reload) begin
          state_nxt = ST_LOAD;
        end else begin
          en_clr_c  = 1'b1;
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
    // A register write acknowledges the interrupt and beats a same-cycle set.
    if (reg_write) pending_nxt = 1'b0;
  end

endmodule

// File: rtl/timer_dev.sv
// Memory-mapped countdown timer: CTRL/PRESET registers, read mux and irq gating.
// Define TIMER_AUTORELOAD_EN to implement the CTRL MODE field (auto-reload pulses).
module timer_dev
  import timer_pkg::*;
#(
  parameter int unsigned CNT_W = 32
) (
  input  logic        clk,
  input  logic        reset,
  timer_dev_if.slave  bus,
  output logic        irq
);

  ctrl_t            ctrl_q;
  logic [CNT_W-1:0] preset_q;
  logic [CNT_W-1:0] count;
  logic [1:0]       mode;
  logic             in_int;
  logic             pending;
  logic             en_clr_c;
  logic             wr_ctrl;
  logic             wr_preset;

  assign wr_ctrl   = bus.we && (bus.addr == OFF_CTRL);
  assign wr_preset = bus.we && (bus.addr == OFF_PRESET);

`ifdef TIMER_AUTORELOAD_EN
  assign mode = ctrl_q.mode;
`else
  assign mode = MODE_ONESHOT;
`endif

  // A CPU write to CTRL overrides the hardware EN-clear in the same cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ctrl_q <= '0;
    end else if (wr_ctrl) begin
      ctrl_q.en   <= bus.wdata[CTRL_EN_BIT];
      ctrl_q.im   <= bus.wdata[CTRL_IM_BIT];
`ifdef TIMER_AUTORELOAD_EN
      ctrl_q.mode <= bus.wdata[CTRL_MODE_MSB:CTRL_MODE_LSB];
`endif
    end else if (en_clr_c) begin
      ctrl_q.en <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      preset_q <= '0;
    end else if (wr_preset) begin
      preset_q <= CNT_W'(bus.wdata);
    end
  end

  timer_fsm #(.CNT_W(CNT_W)) u_fsm (
    .clk       (clk),
    .reset     (reset),
    .en        (ctrl_q.en),
    .mode      (mode),
    .preset    (preset_q),
    .reg_write (wr_ctrl | wr_preset),
    .count     (count),
    .in_int    (in_int),
    .pending   (pending),
    .en_clr_c  (en_clr_c)
  );

  always_comb begin
    bus.rdata = '0;
    case (bus.addr)
      OFF_CTRL:   bus.rdata = ctrl_word(ctrl_q);
      OFF_PRESET: bus.rdata = BUS_W'(preset_q);
      OFF_COUNT:  bus.rdata = BUS_W'(count);
      default:    bus.rdata = '0;
    endcase
  end

  // Sticky one-shot level plus a one-cycle pulse while INT in auto-reload.
  assign irq = ctrl_q.im & (pending | (in_int & (mode == MODE_RELOAD)));

endmodule

// File: doc/timer_dev.md
# timer_dev

Memory-mapped programmable countdown timer for the pipelined MIPS CPU (P7). It sits on the CPU's system bridge beside data memory. The CPU writes and reads it through load/store instructions. Its `irq` output drives one hardware-interrupt line into the CP0 cause register. It turns elapsed clock cycles into interrupts, so the top-level bench can exercise the exception/interrupt path with no external stimulus beyond `clk` and `reset`.

## Interface
- `CNT_W`, default 32: width of PRESET and COUNT.
- `clk`, input, 1: single clock; all state updates on rising edge.
- `reset`, input, 1: asynchronous, active-high; clears all state immediately.
- `addr`, input, 2: word offset, from bridge address bits [3:2]. 0 = CTRL, 1 = PRESET, 2 = COUNT, 3 = unused.
- `we`, input, 1: write strobe, sampled on the rising edge.
- `wdata`, input, 32: write data.
- `rdata`, output, 32: combinational read of the addressed register.
- `irq`, output, 1: interrupt request to CP0.

## Operation
- CTRL fields:
  - bit0 EN: enable.
  - bits[2:1] MODE: 0 = one-shot, 1 = auto-reload; 2 and 3 behave as 0.
  - bit3 IM: interrupt mask, 1 = allowed.
  - Bits [31:4] read as 0.
- PRESET is read/write. COUNT is read-only; writes to it are ignored. Offset 3 reads 0.
- FSM states and transitions:
  - IDLE: if EN = 1, go to LOAD.
  - LOAD: COUNT ← PRESET; go to CNT.
  - CNT: if EN = 0, go to IDLE with COUNT held. Else if COUNT = 0, go to INT. Else COUNT ← COUNT − 1.
  - INT, MODE 0: clear EN, set `pending`, go to IDLE.
  - INT, MODE 1: go to LOAD; `pending` is not set.
- `irq` = IM & (`pending` | (state = INT & MODE = 1)).
  - One-shot interrupts are level and sticky.
  - Auto-reload interrupts are one-cycle pulses.
- `pending` clears on any write to CTRL or PRESET.
- Writing PRESET during CNT does not change the in-flight COUNT; the new value loads at the next LOAD.
- Simultaneous CPU write to CTRL and hardware EN-clear in INT: the CPU write wins, so the written EN value stands.
- COUNT arithmetic is unsigned `CNT_W`-bit and never underflows; 0 is terminal.

## Timing
- Reset values:
  - CTRL = 0, PRESET = 0, COUNT = 0.
  - state = IDLE, `pending` = 0, `irq` = 0.
  - `rdata` shows 0 for offsets 0–3.
- Write latency: register value visible on `rdata` in the cycle after the write edge.
- Edge sequence after an EN = 1 write at edge E0, with PRESET = N:
  - E1: LOAD.
  - E2: COUNT = N, state CNT.
  - E2+N: COUNT = 0.
  - E2+N+1: INT, `irq` asserted.
  - Total: `irq` rises N+3 edges after the write.
- MODE 0: edge E2+N+2 returns to IDLE with EN = 0; `irq` stays high until CTRL or PRESET is written.
- MODE 1: `irq` is high exactly one cycle; period is N+3 cycles.
- PRESET = 0: `irq` rises 3 edges after the enable write.
- `reset` mid-count: immediate return to all reset values, no `irq` glitch. After release, the timer stays idle until reprogrammed.

## Configuration
- Macro: `TIMER_AUTORELOAD_EN`.
- Defined: MODE field is implemented as described above.
- Undefined:
  - MODE bits are not stored and read as 0.
  - INT always behaves as MODE 0.
  - The one-cycle pulse term of `irq` is removed.

## Structure
- Package `timer_pkg` holds:
  - FSM state enum (IDLE, LOAD, CNT, INT).
  - Register offsets (CTRL = 0, PRESET = 1, COUNT = 2).
  - CTRL bit positions and MODE encodings.
- One sub-module, `timer_fsm`, holds the state register, COUNT, and `pending`. It takes EN, MODE and PRESET as inputs and outputs COUNT, the INT state, and an EN-clear request.
- `timer_dev` holds CTRL, PRESET, read mux, write decode and the `irq` gating.

## Test plan
- Reset, then read offsets 0–3 → all 0, `irq` = 0.
- Sequence: PRESET = 5, then CTRL = 0x9 (EN = 1, IM = 1, MODE = 0).
  - Required: `irq` rises 8 edges after the CTRL write and stays high; CTRL reads 0x8.
  - Then write CTRL = 0 → `irq` falls next cycle.
- Sequence: PRESET = 3, then CTRL = 0xB (MODE = 1).
  - Required: `irq` one-cycle pulses every 6 cycles; COUNT sequence 3, 2, 1, 0.
  - Without `TIMER_AUTORELOAD_EN`: a single sticky interrupt and CTRL reads 0x8.
- Sequence: PRESET = 10, EN = 1, IM = 0.
  - Required: `irq` stays 0; `pending` is set, so setting IM = 1 by CTRL write clears it → `irq` stays 0.
- Sequence: PRESET = 100, enable, write CTRL = 0 at COUNT = 50.
  - Required: COUNT frozen at 50–49 (per edge alignment), state IDLE.
  - Re-enable → COUNT reloads 100.
- Sequence: PRESET = 20, enable, assert `reset` at COUNT = 7.
  - Required: all outputs 0 immediately; no `irq` afterward.
